// File: rtl/led_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//   - Segment bit positions within the 8-bit segment bus {dp,g,f,e,d,c,b,a}
//   - Per-digit entry record {blink, blank, dp, code}
//   - 16-entry active-high hex glyph table (bits {g,f,e,d,c,b,a})
package led_pkg;

  localparam int unsigned SegA  = 0;
  localparam int unsigned SegB  = 1;
  localparam int unsigned SegC  = 2;
  localparam int unsigned SegD  = 3;
  localparam int unsigned SegE  = 4;
  localparam int unsigned SegF  = 5;
  localparam int unsigned SegG  = 6;
  localparam int unsigned SegDp = 7;

  typedef struct packed {
    logic       blink;
    logic       blank;
    logic       dp;
    logic [3:0] code;
  } entry_t;

  // Entries come out of reset blanked so nothing lights before software writes.
  localparam entry_t EntryReset = '{blink: 1'b0, blank: 1'b1, dp: 1'b0, code: 4'h0};

  // Index 0 is the rightmost element: glyph for code 0 is 7'h3F.
  localparam logic [15:0][6:0] HexGlyph = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

endpackage

// File: rtl/led7_hexdec.sv
// Hex-to-7-segment decoder, active-high outputs.
// Ports:
//   code  in  4  hex digit to decode
//   dp    in  1  decimal point
//   seg   out 8  segments {dp,g,f,e,d,c,b,a}, 1 = lit
module led7_hexdec
  import led_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg        = '0;
    seg[SegG:SegA] = HexGlyph[code];
    seg[SegDp] = dp;
  end

endmodule

// File: rtl/led7_muxn.sv
// Time-multiplexed driver for DIGITS 7-segment digits.
// Each digit owns a slot of 2^SLOT_W clocks; the digit enable is held off for
// the first DEAD clocks of a slot (anti-ghosting) and then gated by a simple
// brightness PWM taken from the top BRIGHT_W bits of the slot phase.
// Optional feature: define LED7_BLINK_EN to add an 8-bit frame counter; digits
// with the blink attribute go dark while counter bit 7 is set.
// Ports:
//   clk_in      in  1         clock
//   init        in  1         asynchronous active-high reset
//   wrn         in  1         active-low write strobe
//   addr        in  ADDR_W    digit index to write
//   data        in  4         hex code to write
//   dp_in       in  1         decimal point to write
//   blank_in    in  1         blank attribute to write
//   blink_in    in  1         blink attribute to write (ignored without LED7_BLINK_EN)
//   bright      in  BRIGHT_W  global brightness
//   seg         out 8         segments {dp,g,f,e,d,c,b,a}
//   pos         out DIGITS    digit enables
//   frame_tick  out 1         pulse when the scan wraps to digit 0
module led7_muxn
  import led_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SLOT_W      = 10,
  parameter int unsigned DEAD        = 8,
  parameter int unsigned BRIGHT_W    = 3,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned POS_ACT_LOW = 1
) (
  input  logic                clk_in,
  input  logic                init,
  input  logic                wrn,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [3:0]          data,
  input  logic                dp_in,
  input  logic                blank_in,
  input  logic                blink_in,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   pos,
  output logic                frame_tick
);

  // XOR masks that turn active-high internal values into pin polarity.
  localparam logic [7:0]        SegOff = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] PosOff = (POS_ACT_LOW != 0) ? '1 : '0;

  logic [SLOT_W-1:0] ph_q;
  logic [ADDR_W-1:0] dig_q;
  logic              frame_tick_q;
  entry_t            ent_q [DIGITS];
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] pos_q;

  entry_t            cur;
  logic              blank_eff;
  logic              ph_wrap;
  logic              last_dig;
  logic [7:0]        seg_raw;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] pos_d;
  logic              lit;

  assign cur      = ent_q[dig_q];
  assign ph_wrap  = (ph_q == '1);
  assign last_dig = (dig_q == ADDR_W'(DIGITS - 1));

  // Scan counters.
  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      ph_q         <= '0;
      dig_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      ph_q         <= ph_q + 1'b1;
      frame_tick_q <= ph_wrap && last_dig;
      if (ph_wrap) begin
        dig_q <= last_dig ? '0 : dig_q + 1'b1;
      end
    end
  end

  // Digit entry storage; out-of-range addresses are dropped.
  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      for (int i = 0; i < DIGITS; i++) begin
        ent_q[i] <= EntryReset;
      end
    end else if (!wrn && (32'(addr) < DIGITS)) begin
      ent_q[addr] <= '{blink: blink_in, blank: blank_in, dp: dp_in, code: data};
    end
  end

`ifdef LED7_BLINK_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      fcnt_q <= '0;
    end else if (frame_tick_q) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign blank_eff = cur.blank | (cur.blink & fcnt_q[7]);
`else
  logic unused_blink;

  assign unused_blink = cur.blink;
  assign blank_eff    = cur.blank;
`endif

  led7_hexdec u_hexdec (
    .code (cur.code),
    .dp   (cur.dp),
    .seg  (seg_raw)
  );

  // Enable window: past the dead time and inside the brightness share of the slot.
  assign lit = (ph_q >= SLOT_W'(DEAD)) &&
               (ph_q[SLOT_W-1 -: BRIGHT_W] <= bright) &&
               !blank_eff;

  always_comb begin
    pos_d = '0;
    if (lit) begin
      pos_d[dig_q] = 1'b1;
    end
    seg_d = blank_eff ? 8'h00 : seg_raw;
  end

  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      seg_q <= SegOff;
      pos_q <= PosOff;
    end else begin
      seg_q <= seg_d ^ SegOff;
      pos_q <= pos_d ^ PosOff;
    end
  end

  assign seg        = seg_q;
  assign pos        = pos_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led7_muxn.sv
// Directed bench for led7_muxn with DIGITS=6, SLOT_W=4, DEAD=2, BRIGHT_W=2,
// active-low seg and pos. All stimulus and sampling happens on falling edges;
// cyc counts rising edges since the last init release, so the outputs seen at
// cyc=c reflect scan state s=c-1 (digit (s/16)%6, phase s%16).
module tb_led7_muxn;

  logic       clk_in = 1'b0;
  logic       init = 1'b1;
  logic       wrn = 1'b1;
  logic [2:0] addr = '0;
  logic [3:0] data = '0;
  logic       dp_in = 1'b0;
  logic       blank_in = 1'b0;
  logic       blink_in = 1'b0;
  logic [1:0] bright = 2'd3;
  logic [7:0] seg;
  logic [5:0] pos;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  led7_muxn #(
    .DIGITS      (6),
    .ADDR_W      (3),
    .SLOT_W      (4),
    .DEAD        (2),
    .BRIGHT_W    (2),
    .SEG_ACT_LOW (1),
    .POS_ACT_LOW (1)
  ) dut (
    .clk_in     (clk_in),
    .init       (init),
    .wrn        (wrn),
    .addr       (addr),
    .data       (data),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_in   (blink_in),
    .bright     (bright),
    .seg        (seg),
    .pos        (pos),
    .frame_tick (frame_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p,
                    input logic bl, input logic bk);
    addr = a; data = d; dp_in = p; blank_in = bl; blink_in = bk;
    wrn = 1'b0;
    step();
    wrn = 1'b1;
  endtask

  task automatic release_init();
    init = 1'b1;
    step();
    step();
    init = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int s, d, p;
    logic dark;
    logic [7:0] exp_seg, exp_pos;
    int frames [7] = '{0, 1, 127, 128, 129, 255, 256};

    // Reset state while init is held.
    @(negedge clk_in);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_pos", {2'b00, pos}, 8'h3F);
    chk("rst_ft", {7'd0, frame_tick}, 8'd0);
    release_init();

    // No writes: everything stays dark; frame tick at cyc 96.
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_pos", {2'b00, pos}, 8'h3F);
      chk("idle_seg", seg, 8'hFF);
      chk("idle_ft", {7'd0, frame_tick}, {7'd0, cyc == 96});
    end

    // Digit 2 = 'A', full brightness: frame 1 slot shown at cyc 129..144.
    bright = 2'd3;
    wr(3'd2, 4'hA, 1'b0, 1'b0, 1'b0);
    step_to(128);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("b3_pos", {2'b00, pos}, (i >= 2) ? 8'h3B : 8'h3F);
      chk("b3_seg", seg, 8'h88);
    end

    // Brightness 0: only phases 2..3 lit (frame 2, cyc 225..240).
    step_to(200);
    bright = 2'd0;
    step_to(224);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("b0_pos", {2'b00, pos}, (i == 2 || i == 3) ? 8'h3B : 8'h3F);
      chk("b0_seg", seg, 8'h88);
    end

    // Brightness change mid-slot (frame 3, digit 2 phase 5 -> 6).
    step_to(326);
    chk("midb_before", {2'b00, pos}, 8'h3F);
    bright = 2'd3;
    step();
    chk("midb_after", {2'b00, pos}, 8'h3B);

    // Write to the digit on display mid-slot (frame 4).
    step_to(420);
    wr(3'd2, 4'h5, 1'b0, 1'b0, 1'b0);
    step();
    chk("midw_seg", seg, 8'h92);
    chk("midw_pos", {2'b00, pos}, 8'h3B);

    // Out-of-range addresses leave every entry unchanged over a full frame.
    step_to(480);
    wr(3'd7, 4'h8, 1'b1, 1'b0, 1'b0);
    wr(3'd6, 4'h8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 96; i++) begin
      step();
      s = cyc - 1;
      d = (s / 16) % 6;
      p = s % 16;
      chk("oor_seg", seg, (d == 2) ? 8'h92 : 8'hFF);
      chk("oor_pos", {2'b00, pos}, (d == 2 && p >= 2) ? 8'h3B : 8'h3F);
    end

    // Digit 4 = '3'; assert init at digit 4 phase 9 and check the async clear.
    step_to(600);
    wr(3'd4, 4'h3, 1'b0, 1'b0, 1'b0);
    step_to(745);
    chk("pre_init_pos", {2'b00, pos}, 8'h2F);
    chk("pre_init_seg", seg, 8'hB0);
    init = 1'b1;
    #1;
    chk("async_pos", {2'b00, pos}, 8'h3F);
    chk("async_seg", seg, 8'hFF);
    chk("async_ft", {7'd0, frame_tick}, 8'd0);
    @(negedge clk_in);
    release_init();

    // Restart from digit 0 phase 0; frame tick every 96 clocks.
    wr(3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rs_pos1", {2'b00, pos}, 8'h3F);
    chk("rs_seg1", seg, 8'hFF);
    for (int i = 0; i < 289; i++) begin
      step();
      s = cyc - 1;
      d = (s / 16) % 6;
      p = s % 16;
      chk("rs_ft", {7'd0, frame_tick}, {7'd0, (cyc % 96) == 0});
      chk("rs_pos", {2'b00, pos}, (d == 0 && p >= 2) ? 8'h3E : 8'h3F);
      chk("rs_seg", seg, (d == 0) ? 8'hC0 : 8'hFF);
      if (d == 4) chk("rs_d4_clr", {2'b00, pos}, 8'h3F);
    end

    // Blink attribute on digit 1.
    release_init();
    wr(3'd1, 4'h1, 1'b0, 1'b0, 1'b1);
    foreach (frames[k]) begin
      step_to(96 * frames[k] + 21);
`ifdef LED7_BLINK_EN
      dark = ((frames[k] % 256) >= 128);
`else
      dark = 1'b0;
`endif
      exp_pos = dark ? 8'h3F : 8'h3D;
      exp_seg = dark ? 8'hFF : 8'hF9;
      chk("blink_pos", {2'b00, pos}, exp_pos);
      chk("blink_seg", seg, exp_seg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led7_muxn.md
LED7_MUXN -- requirements
Module: led7_muxn

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning number of multiplexed digits (2..16).
REQ-002 SHALL have parameter ADDR_W, default 3, meaning write address width, with 2^ADDR_W >= DIGITS.
REQ-003 SHALL have parameter SLOT_W, default 10, meaning digit slot length of 2^SLOT_W clocks.
REQ-004 SHALL have parameter DEAD, default 8, meaning anti-ghost clocks at slot start, with DEAD < 2^(SLOT_W-BRIGHT_W).
REQ-005 SHALL have parameter BRIGHT_W, default 3, meaning brightness input width, with BRIGHT_W < SLOT_W.
REQ-006 SHALL have parameter SEG_ACT_LOW, default 1, meaning seg outputs are active-low.
REQ-007 SHALL have parameter POS_ACT_LOW, default 1, meaning pos outputs are active-low.
REQ-008 SHALL have the following ports; the block has one clock, and reset is asynchronous and active-high:
- clk_in  in  1  clock.
- init  in  1  asynchronous active-high reset.
- wrn  in  1  active-low write strobe, sampled on rising clk_in.
- addr  in  ADDR_W  digit index to write.
- data  in  4  hex code to write.
- dp_in  in  1  decimal point to write.
- blank_in  in  1  digit blank attribute to write.
- blink_in  in  1  blink attribute to write.
- bright  in  BRIGHT_W  global brightness.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}.
- pos  out  DIGITS  digit enables, one-hot when active.
- frame_tick  out  1  one-clock pulse at each wrap of the scan to digit 0.

Function
REQ-009 SHALL hold DIGITS entries of {blink, blank, dp, code[3:0]}; a clock edge with wrn=0 and addr<DIGITS SHALL write entry[addr], and writes with addr>=DIGITS SHALL be ignored.
REQ-010 SHALL run a slot phase counter ph from 0 to 2^SLOT_W-1; at wrap, digit index SHALL advance, going from DIGITS-1 back to 0.
REQ-011 SHALL assert frame_tick for exactly the one clock in which the digit index changes from DIGITS-1 to 0.
REQ-012 SHALL drive the current digit's pos bit active iff ph>=DEAD, ph[SLOT_W-1 -: BRIGHT_W]<=bright, and the digit is not blanked; all other pos bits SHALL be inactive.
REQ-013 SHALL drive seg from the hex decode of code (0-F standard glyphs), with bit 7 taken from dp; a blanked digit SHALL drive all segments inactive.
REQ-014 SHALL register seg and pos, so outputs lag the counter state by 1 clock; a write SHALL be visible on outputs no later than 2 clocks after the write edge.
REQ-015 SHALL apply a write to the currently displayed digit mid-slot, without waiting for the next slot.
REQ-016 SHALL apply a change of bright within the current slot.

Reset
REQ-017 While init=1, the block SHALL asynchronously set: ph=0, digit index=0, all entries {0,1,0,0} (blanked), seg all inactive, pos all inactive, frame_tick=0, blink counter=0.
REQ-018 After init deasserts, scanning SHALL restart from digit 0 with ph=0; an init asserted mid-slot SHALL abort the slot.

Configuration
REQ-019 With macro LED7_BLINK_EN defined, the block SHALL contain an 8-bit frame counter incremented on frame_tick, and a digit with blink=1 SHALL be blanked while counter bit 7 is 1.
REQ-020 Without LED7_BLINK_EN, the blink_in port SHALL remain present but be ignored, and no frame counter SHALL be synthesized.

Structure
REQ-021 Package led_pkg SHALL hold the segment bit-order constants, the digit-entry typedef and the 16-entry hex glyph table.
REQ-022 Sub-module led7_hexdec (4-bit code plus dp in, 8-bit active-high segments out) SHALL perform decoding; polarity inversion SHALL be done in led7_muxn.

Verification (DIGITS=6, ADDR_W=3, SLOT_W=4, DEAD=2, BRIGHT_W=2, both polarities active-low)
REQ-023 Bench SHALL cover: init pulse -> seg=8'hFF, pos=6'h3F, frame_tick=0, and pos remains 6'h3F with no writes.
REQ-024 Bench SHALL cover: write addr=2, data=4'hA, dp=0, blank=0, bright=3 -> during digit 2 slot, pos=6'b111011 for ph 2..15 and seg=8'h88.
REQ-025 Bench SHALL cover: same setup with bright=0 -> pos active only for ph 2..3, and 6'h3F otherwise.
REQ-026 Bench SHALL cover: write addr=7 -> no entry changes, and output matches the pre-write trace.
REQ-027 Bench SHALL cover: init asserted at ph=9 of digit 4 -> pos=6'h3F in the same cycle; after release, digit 0 slot starts with ph=0, and frame_tick occurs every 96 clocks.
REQ-028 Bench SHALL cover: with LED7_BLINK_EN, write addr=1, blink=1 -> digit 1 is dark for frames 128..255 and lit for frames 0..127; without LED7_BLINK_EN, digit 1 is always lit.
